code_patch_unit: RTL and testbench

Parametrised code-patch engine on the instruction/data read path. It holds NUM_REGS programmable (address, data, enable) patch entries. It snoops each bus read request and, when the address matches an enabled entry, substitutes the entry's data for the memory response and flags no-propagation. It also keeps a saturating hit counter. It sits between the bus wrapper and the memory response path.

---
 rtl/code_patch_unit.sv | 180 ++++++++++++++++++
 tb/tb_code_patch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_patch_unit.sv
// -----------------------------------------------------------------------------
// code_patch_unit
//
// Code-patch engine on the instruction/data read path. Holds NUM_REGS
// programmable (address, data, enable) entries. Each bus read request is
// compared against the table. On a hit, the entry's data replaces the memory
// response and nopg_o is flagged. The response is still released only after
// the memory answers, so bus ordering is preserved. A saturating counter
// tracks patched responses.
//
// Ports
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   cfg_we_i           entry write strobe; cfg_idx_i selects the entry
//   cfg_addr_i         match address written into the entry
//   cfg_data_i         replacement data written into the entry
//   cfg_en_i           entry enable written into the entry
//   cfg_pat_gen_i      global patch enable
//   cnt_clr_i          synchronous hit counter clear (beats increment)
//   si_read_i          read request strobe
//   si_addr_i          read request address
//   mem_rvalid_i       memory response valid
//   mem_rdata_i        memory response data
//   rdata_o            response data (held between pulses)
//   rvalid_o           one-cycle response pulse
//   nopg_o             response was patched
//   hit_idx_o          matched entry index (0 on a miss)
//   busy_o             request outstanding
//   hit_cnt_o          saturating count of patched responses
// -----------------------------------------------------------------------------
module code_patch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_LSB   = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_we_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0] cfg_data_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_pat_gen_i,
    input  logic                  cnt_clr_i,
    input  logic                  si_read_i,
    input  logic [ADDR_WIDTH-1:0] si_addr_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  nopg_o,
    output logic [IDX_W-1:0]      hit_idx_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    // Word-granularity compare: the low ADDR_LSB bits are masked out.
    localparam logic [ADDR_WIDTH-1:0] TAG_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;
    localparam logic [IDX_W:0]        NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

    logic [ADDR_WIDTH-1:0] ent_addr [NUM_REGS];
    logic [DATA_WIDTH-1:0] ent_data [NUM_REGS];
    logic [NUM_REGS-1:0]   ent_en;

    state_t                state_q, state_d;
    logic                  hit_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] snap_q;

    logic                  match_hit;
    logic [IDX_W-1:0]      match_idx;
    logic [DATA_WIDTH-1:0] match_data;
    logic                  cfg_ok;
    logic                  accept;
    logic                  respond;

    assign cfg_ok  = cfg_we_i && ({1'b0, cfg_idx_i} < NUM_REGS_L);
    assign accept  = (state_q == ST_IDLE) && si_read_i;
    assign respond = (state_q == ST_WAIT) && mem_rvalid_i;
    assign busy_o  = (state_q == ST_WAIT);

    // NOTE: the table is a small register file, not RAM, so it gets a real
    // reset; entries must come up disabled or stale patches could fire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
            ent_en <= '0;
        end else if (cfg_ok) begin
            ent_addr[cfg_idx_i] <= cfg_addr_i;
            ent_data[cfg_idx_i] <= cfg_data_i;
            ent_en[cfg_idx_i]   <= cfg_en_i;
        end
    end

    // Scan from the top down so the lowest matching index is written last.
    // NOTE: combinational blocks use blocking '=' so later assignments
    // override earlier ones within the same evaluation; registers use '<='.
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        match_data = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (cfg_pat_gen_i && ent_en[i] &&
                (((ent_addr[i] ^ si_addr_i) & TAG_MASK) == '0)) begin
                match_hit  = 1'b1;
                match_idx  = IDX_W'(i);
                match_data = ent_data[i];
            end
        end
    end

    // NOTE: next-state has a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (si_read_i)    state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid_i) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot the match result at accept time; later table or global-enable
    // changes cannot alter the in-flight response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q  <= 1'b0;
            idx_q  <= '0;
            snap_q <= '0;
        end else if (accept) begin
            hit_q  <= match_hit;
            idx_q  <= match_idx;
            snap_q <= match_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            nopg_o    <= 1'b0;
            hit_idx_o <= '0;
        end else begin
            rvalid_o <= respond;
            if (respond) begin
                rdata_o   <= hit_q ? snap_q : mem_rdata_i;
                nopg_o    <= hit_q;
                hit_idx_o <= hit_q ? idx_q : '0;
            end
        end
    end

    // The count updates on the same edge that raises the patched pulse, so
    // it already includes that response while rvalid_o is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            hit_cnt_o <= '0;
        end else if (respond && hit_q && (hit_cnt_o != '1)) begin
            hit_cnt_o <= hit_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_code_patch_unit.sv
// -----------------------------------------------------------------------------
// tb_code_patch_unit
//
// Bench for code_patch_unit with NUM_REGS=6 (so index 6/7 writes are out of
// range) and CNT_WIDTH=4 (so saturation is reachable). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_code_patch_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 6;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_we_i;
    logic [IW-1:0] cfg_idx_i;
    logic [AW-1:0] cfg_addr_i;
    logic [DW-1:0] cfg_data_i;
    logic          cfg_en_i;
    logic          cfg_pat_gen_i;
    logic          cnt_clr_i;
    logic          si_read_i;
    logic [AW-1:0] si_addr_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          nopg_o;
    logic [IW-1:0] hit_idx_o;
    logic          busy_o;
    logic [CW-1:0] hit_cnt_o;

    int checks = 0;
    int errors = 0;

    code_patch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .ADDR_LSB(2), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_addr_i(cfg_addr_i),
        .cfg_data_i(cfg_data_i), .cfg_en_i(cfg_en_i),
        .cfg_pat_gen_i(cfg_pat_gen_i), .cnt_clr_i(cnt_clr_i),
        .si_read_i(si_read_i), .si_addr_i(si_addr_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .nopg_o(nopg_o),
        .hit_idx_o(hit_idx_o), .busy_o(busy_o), .hit_cnt_o(hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic          cfg_we;
        logic [IW-1:0] cfg_idx;
        logic [AW-1:0] cfg_addr;
        logic [DW-1:0] cfg_data;
        logic          cfg_en;
        logic [AW-1:0] addr;
        logic [DW-1:0] mem;
        logic [DW-1:0] exp_data;
        logic          exp_nopg;
        logic [IW-1:0] exp_idx;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic en);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = idx;
        cfg_addr_i = addr;
        cfg_data_i = data;
        cfg_en_i   = en;
        tick();
        cfg_we_i   = 1'b0;
    endtask

    // Issue one read, hold off the memory for 'gap' cycles, then check the
    // response pulse and that the data holds afterwards.
    task automatic do_read(input string name, input logic [AW-1:0] addr, input int gap,
                           input logic [DW-1:0] mem, input logic [DW-1:0] exp_data,
                           input logic exp_nopg, input logic [IW-1:0] exp_idx,
                           input logic [CW-1:0] exp_cnt, input logic clr);
        si_read_i = 1'b1;
        si_addr_i = addr;
        tick();
        si_read_i = 1'b0;
        check({name, " busy"}, 64'(busy_o), 64'd1);
        for (int i = 1; i < gap; i++) begin
            tick();
            check({name, " busy wait"}, 64'(busy_o), 64'd1);
            check({name, " rvalid wait"}, 64'(rvalid_o), 64'd0);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem;
        cnt_clr_i    = clr;
        tick();
        mem_rvalid_i = 1'b0;
        check({name, " rvalid"}, 64'(rvalid_o), 64'd1);
        check({name, " busy low"}, 64'(busy_o), 64'd0);
        check({name, " rdata"}, 64'(rdata_o), 64'(exp_data));
        check({name, " nopg"}, 64'(nopg_o), 64'(exp_nopg));
        check({name, " hit_idx"}, 64'(hit_idx_o), 64'(exp_idx));
        check({name, " hit_cnt"}, 64'(hit_cnt_o), 64'(exp_cnt));
        tick();
        cnt_clr_i = 1'b0;
        check({name, " pulse ends"}, 64'(rvalid_o), 64'd0);
        check({name, " rdata held"}, 64'(rdata_o), 64'(exp_data));
    endtask

    initial begin
        logic [CW-1:0] exp_cnt;

        vecs[0] = '{1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0000_1004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 3'd3, 4'd1};
        vecs[1] = '{1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0000_1008, 32'h1111_0008, 32'h1111_0008, 1'b0, 3'd0, 4'd1};
        vecs[2] = '{1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0000_1007, 32'h2222_0007, 32'hDEAD_BEEF, 1'b1, 3'd3, 4'd2};
        vecs[3] = '{1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0000_2000, 32'h3333_2000, 32'hAAAA_0002, 1'b1, 3'd2, 4'd3};
        vecs[4] = '{1'b1, 3'd2, 32'h0000_2000, 32'hAAAA_0002, 1'b0, 32'h0000_2000, 32'h3333_2001, 32'hAAAA_0005, 1'b1, 3'd5, 4'd4};
        vecs[5] = '{1'b1, 3'd6, 32'h0000_3000, 32'h6666_6666, 1'b1, 32'h0000_3000, 32'h4444_3000, 32'h4444_3000, 1'b0, 3'd0, 4'd4};
        vecs[6] = '{1'b1, 3'd7, 32'h0000_1008, 32'h7777_7777, 1'b1, 32'h0000_1008, 32'h5555_1008, 32'h5555_1008, 1'b0, 3'd0, 4'd4};
        vecs[7] = '{1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0000_2003, 32'h3333_2003, 32'hAAAA_0005, 1'b1, 3'd5, 4'd5};
        vecs[8] = '{1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 32'h7777_0000, 32'h7777_0000, 1'b0, 3'd0, 4'd5};

        rst_i         = 1'b1;
        cfg_we_i      = 1'b0;
        cfg_idx_i     = '0;
        cfg_addr_i    = '0;
        cfg_data_i    = '0;
        cfg_en_i      = 1'b0;
        cfg_pat_gen_i = 1'b1;
        cnt_clr_i     = 1'b0;
        si_read_i     = 1'b0;
        si_addr_i     = '0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        #12;
        check("reset rdata", 64'(rdata_o), 64'd0);
        check("reset rvalid", 64'(rvalid_o), 64'd0);
        check("reset nopg", 64'(nopg_o), 64'd0);
        check("reset hit_idx", 64'(hit_idx_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset hit_cnt", 64'(hit_cnt_o), 64'd0);
        rst_i = 1'b0;
        tick();

        cfg_write(3'd3, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
        cfg_write(3'd2, 32'h0000_2000, 32'hAAAA_0002, 1'b1);
        cfg_write(3'd5, 32'h0000_2000, 32'hAAAA_0005, 1'b1);

        // Table-driven reads: first vector uses a 3-cycle memory wait.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].cfg_we)
                cfg_write(vecs[v].cfg_idx, vecs[v].cfg_addr, vecs[v].cfg_data, vecs[v].cfg_en);
            do_read($sformatf("vec%0d", v), vecs[v].addr, (v == 0) ? 3 : 2, vecs[v].mem,
                    vecs[v].exp_data, vecs[v].exp_nopg, vecs[v].exp_idx, vecs[v].exp_cnt, 1'b0);
        end

        // Snapshot: table rewrite, global disable and a stray request during WAIT.
        si_read_i = 1'b1;
        si_addr_i = 32'h0000_1004;
        tick();
        check("snap busy", 64'(busy_o), 64'd1);
        cfg_we_i      = 1'b1;
        cfg_idx_i     = 3'd3;
        cfg_addr_i    = 32'h0000_1004;
        cfg_data_i    = 32'h0;
        cfg_en_i      = 1'b1;
        cfg_pat_gen_i = 1'b0;
        si_addr_i     = 32'h0000_2000;
        tick();
        cfg_we_i  = 1'b0;
        si_read_i = 1'b0;
        check("snap still busy", 64'(busy_o), 64'd1);
        check("snap no early rvalid", 64'(rvalid_o), 64'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h9999_0000;
        tick();
        mem_rvalid_i = 1'b0;
        check("snap rvalid", 64'(rvalid_o), 64'd1);
        check("snap rdata", 64'(rdata_o), 64'hDEAD_BEEF);
        check("snap nopg", 64'(nopg_o), 64'd1);
        check("snap hit_idx", 64'(hit_idx_o), 64'd3);
        check("snap hit_cnt", 64'(hit_cnt_o), 64'd6);
        tick();
        check("stray read no pulse", 64'(rvalid_o), 64'd0);
        check("stray read not busy", 64'(busy_o), 64'd0);

        // Memory response with nothing outstanding is ignored.
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        check("idle rvalid ignored", 64'(rvalid_o), 64'd0);
        check("idle busy", 64'(busy_o), 64'd0);
        tick();
        check("idle rvalid ignored 2", 64'(rvalid_o), 64'd0);

        do_read("patgen off", 32'h0000_1004, 2, 32'h1212_1212, 32'h1212_1212, 1'b0, 3'd0, 4'd6, 1'b0);
        cfg_pat_gen_i = 1'b1;
        do_read("rewritten entry", 32'h0000_1004, 1, 32'h1313_1313, 32'h0, 1'b1, 3'd3, 4'd7, 1'b0);

        // Saturation of the 4-bit counter.
        exp_cnt = 4'd7;
        for (int k = 0; k < 17; k++) begin
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            do_read($sformatf("sat%0d", k), 32'h0000_2000, 1, 32'h0BAD_0000,
                    32'hAAAA_0005, 1'b1, 3'd5, exp_cnt, 1'b0);
        end
        check("saturated", 64'(hit_cnt_o), 64'hF);

        // Clear coincident with a patched response wins.
        do_read("clr vs hit", 32'h0000_2000, 1, 32'h0BAD_0001, 32'hAAAA_0005, 1'b1, 3'd5, 4'd0, 1'b1);
        check("clr stays", 64'(hit_cnt_o), 64'd0);

        // Reset in the middle of WAIT.
        si_read_i = 1'b1;
        si_addr_i = 32'h0000_1004;
        tick();
        si_read_i = 1'b0;
        check("pre-reset busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("async reset busy", 64'(busy_o), 64'd0);
        check("async reset cnt", 64'(hit_cnt_o), 64'd0);
        check("async reset rdata", 64'(rdata_o), 64'd0);
        #3;
        rst_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFEED_0000;
        tick();
        mem_rvalid_i = 1'b0;
        check("dropped request no pulse", 64'(rvalid_o), 64'd0);
        do_read("post-reset unpatched", 32'h0000_1004, 2, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 3'd0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
